blake_state_sequencer: RTL
==========================

# blake_state_sequencer

Parametrised BLAKE round-state engine. It holds the 16-word working vector v, sequences the 8 G applications per round (4 columns, then 4 diagonals) across NG parallel G units, and drives operand words out over a valid/ready interface. It scatters G results back into v and, after ROUNDS rounds, presents the final vector to the finalisation stage. It sits between the initialisation block and the external G-function unit(s). Supported configurations are BLAKE-512 (W=64, ROUNDS=16) and BLAKE-256 (W=32, ROUNDS=14).

## Interface
- W, 64: word width in bits.
- NG, 1: G units per issue slot; legal values 1, 2, 4; any other value is an elaboration error.
- ROUNDS, 16: rounds per block.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_valid  in  1  init_v is valid.
- init_ready  out  1  high only in IDLE.
- init_v  in  16W  initial v; v0 in the MSBs, v15 in the LSBs.
- g_valid_o  out  1  operand slot valid.
- g_ready_i  in  1  G unit accepts the slot.
- g_a_o, g_b_o, g_c_o, g_d_o  out  NG·W each  operands; unit k uses bits [(NG-k)W-1 -: W].
- g_step_o  out  3  step of unit 0 in this slot; unit k handles step g_step_o+k.
- g_round_o  out  5  current round index, 0..ROUNDS-1.
- g_res_valid_i  in  1  result words valid.
- g_a_i, g_b_i, g_c_i, g_d_i  in  NG·W each  G outputs, same packing as the operands.
- done_valid  out  1  v_final valid.
- done_ready  in  1  consumer accepts v_final.
- v_final  out  16W  final v, same packing as init_v.
- err_o  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
  - IDLE: init_ready=1. When init_valid is high, load v←init_v, clear slot=0 and round=0, and go to ISSUE.
  - ISSUE: g_valid_o=1 and operands are stable. When g_ready_i is high, go to WAIT.
  - WAIT: when g_res_valid_i is high, write the results into v and advance slot. If slot wraps (8/NG slots per round), increment round. After the last slot of round ROUNDS-1, go to DONE; otherwise go to ISSUE.
  - DONE: done_valid=1 and v_final=v. When done_ready is high, go to IDLE.
- Step s = slot·NG + k.
  - Column i = s for s<4: a=v[i], b=v[4+i], c=v[8+i], d=v[12+i].
  - Diagonal j = s−4 for s≥4: a=v[j], b=v[4+(j+1)%4], c=v[8+(j+2)%4], d=v[12+(j+3)%4].
- Write-back uses the same index map. The NG steps in one slot never alias words.
- Exactly one slot is outstanding at a time. Results are never applied outside WAIT.
- g_res_valid_i in IDLE, ISSUE or DONE is ignored and v is unchanged.
- Counter widths: slot is $clog2(8/NG) bits minimum 1; round is 5 bits and wraps to 0 on completion.

## Timing
- Reset: state=IDLE, v=0, slot=0, round=0, g_valid_o=0, done_valid=0, err_o=0, all operand outputs 0. init_ready=1 once rst_n deasserts.
- Reset mid-operation aborts immediately, leaves no partial output, and the block returns to IDLE.
- Init accepted at edge 0 → ISSUE in cycle 1.
- Slot cost is 1+L cycles, where L ≥ 1 is the G latency from issue handshake to g_res_valid_i.
- done_valid rises in cycle 1 + ROUNDS·(8/NG)·(1+L). Example: NG=1, ROUNDS=16, L=1 gives cycle 257.
- Outputs are registered or state-decoded. No combinational path from g_res_valid_i to g_valid_o.
- done_valid and v_final are held stable while done_ready is low. done_ready arriving in the same cycle as done_valid rises completes the transfer in that cycle.

## Configuration
- BLAKE_STATE_PROTO_CHK_EN defined: err_o is set and held until reset when either of these occurs:
  - g_res_valid_i is high outside WAIT;
  - init_valid drops while high in IDLE, which cannot happen because IDLE accepts immediately, so this check is omitted.
  In practice the only trigger is g_res_valid_i outside WAIT.
- Undefined: err_o is tied to 0 and no checking logic is built.

## Structure
- blake_pkg holds:
  - the state enum;
  - functions a_idx(step), b_idx(step), c_idx(step), d_idx(step) returning 0..15;
  - constants W512=64, W256=32, R512=16, R256=14.
- One sub-module, blake_state_merge: combinational NG-lane scatter of the G results into v for a given slot. The sequencer instantiates it once.

## Test plan
- NG=1, W=64, ROUNDS=16, identity G with L=1, init_v = words 0..15 → v_final == init_v; done_valid in cycle 257.
- NG=1, G returns a+1, b+1, c+1, d+1 → every word of v_final equals its init value + 32, mod 2^64.
- NG=1, slot 4, round 0 → g_a_o=v0, g_b_o=v5, g_c_o=v10, g_d_o=v15; g_step_o=4.
- NG=4, W=32, ROUNDS=14, g_ready_i low for 3 cycles on each slot → exactly 28 slots issued; operands held during the stall; result matches the NG=1 run for the same G.
- done_ready held low for 5 cycles → done_valid and v_final stable; init_ready=0 until the transfer, then 1.
- rst_n pulsed low in WAIT at round 7 → all outputs return to reset values. A new init completes normally. With BLAKE_STATE_PROTO_CHK_EN, a stray g_res_valid_i in ISSUE sets err_o=1.

Source files
------------

// File: rtl/blake_pkg.sv
// blake_pkg: shared types and helpers for the BLAKE round-state engine.
//   state_e          : sequencer FSM states
//   a_idx..d_idx     : map a G step (0..7) to the v word index (0..15)
//   W512/W256        : word widths for BLAKE-512 / BLAKE-256
//   R512/R256        : round counts for BLAKE-512 / BLAKE-256
package blake_pkg;

  localparam int unsigned W512 = 64;
  localparam int unsigned W256 = 32;
  localparam int unsigned R512 = 16;
  localparam int unsigned R256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Steps 0..3 are columns, 4..7 diagonals. step[1:0] is the column /
  // diagonal number; diagonals rotate rows b, c, d by 1, 2, 3 (mod 4).
  function automatic logic [3:0] a_idx(input logic [2:0] step);
    return {2'b00, step[1:0]};
  endfunction

  function automatic logic [3:0] b_idx(input logic [2:0] step);
    logic [1:0] j;
    j = step[1:0] + {1'b0, step[2]};
    return {2'b01, j};
  endfunction

  function automatic logic [3:0] c_idx(input logic [2:0] step);
    logic [1:0] j;
    j = step[1:0] + {step[2], 1'b0};
    return {2'b10, j};
  endfunction

  function automatic logic [3:0] d_idx(input logic [2:0] step);
    logic [1:0] j;
    j = step[1:0] + {step[2], step[2]};
    return {2'b11, j};
  endfunction

endpackage

// File: rtl/blake_state_merge.sv
// blake_state_merge: combinational scatter of NG G-unit results into v.
//   W, NG, SW : word width, G lanes per slot, slot counter width
//   v_i       : current working vector (v0 in MSBs)
//   slot_i    : slot whose results are being written back
//   a_i..d_i  : G results, lane k at [(NG-k)*W-1 -: W]
//   v_o       : v with the slot's words replaced
module blake_state_merge
  import blake_pkg::*;
#(
  parameter int unsigned W  = 64,
  parameter int unsigned NG = 1,
  parameter int unsigned SW = 3
) (
  input  logic [16*W-1:0] v_i,
  input  logic [SW-1:0]   slot_i,
  input  logic [NG*W-1:0] a_i,
  input  logic [NG*W-1:0] b_i,
  input  logic [NG*W-1:0] c_i,
  input  logic [NG*W-1:0] d_i,
  output logic [16*W-1:0] v_o
);

  logic [W-1:0] vw [16];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      vw[i] = v_i[(16-i)*W-1 -: W];
    end
    // Lanes in one slot touch disjoint words, so write order is irrelevant.
    for (int unsigned k = 0; k < NG; k++) begin
      vw[a_idx(3'(32'(slot_i) * NG + k))] = a_i[(NG-k)*W-1 -: W];
      vw[b_idx(3'(32'(slot_i) * NG + k))] = b_i[(NG-k)*W-1 -: W];
      vw[c_idx(3'(32'(slot_i) * NG + k))] = c_i[(NG-k)*W-1 -: W];
      vw[d_idx(3'(32'(slot_i) * NG + k))] = d_i[(NG-k)*W-1 -: W];
    end
    v_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      v_o[(16-i)*W-1 -: W] = vw[i];
    end
  end

endmodule

// File: rtl/blake_state_sequencer.sv
// blake_state_sequencer: BLAKE round-state engine. Holds v, issues the
// 8 G steps per round (columns then diagonals) over NG lanes per slot,
// scatters results back and hands the final v to finalisation.
//   init_valid/init_ready/init_v   : initial vector intake (IDLE only)
//   g_valid_o/g_ready_i            : operand slot handshake
//   g_a_o..g_d_o, g_step_o, g_round_o : operands and position of the slot
//   g_res_valid_i, g_a_i..g_d_i    : G results (applied only in WAIT)
//   done_valid/done_ready/v_final  : final vector handoff
//   err_o                          : sticky protocol error
// Optional: define BLAKE_STATE_PROTO_CHK_EN to flag g_res_valid_i outside
// WAIT on err_o; otherwise err_o is constant 0.
module blake_state_sequencer
  import blake_pkg::*;
#(
  parameter int unsigned W      = 64,
  parameter int unsigned NG     = 1,
  parameter int unsigned ROUNDS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_valid,
  output logic            init_ready,
  input  logic [16*W-1:0] init_v,
  output logic            g_valid_o,
  input  logic            g_ready_i,
  output logic [NG*W-1:0] g_a_o,
  output logic [NG*W-1:0] g_b_o,
  output logic [NG*W-1:0] g_c_o,
  output logic [NG*W-1:0] g_d_o,
  output logic [2:0]      g_step_o,
  output logic [4:0]      g_round_o,
  input  logic            g_res_valid_i,
  input  logic [NG*W-1:0] g_a_i,
  input  logic [NG*W-1:0] g_b_i,
  input  logic [NG*W-1:0] g_c_i,
  input  logic [NG*W-1:0] g_d_i,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [16*W-1:0] v_final,
  output logic            err_o
);

  localparam int unsigned SLOTS = (NG == 0) ? 8 : 8 / NG;
  localparam int unsigned SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT  = SW'(SLOTS - 1);
  localparam logic [4:0]    LAST_ROUND = 5'(ROUNDS - 1);

  if (!(NG == 1 || NG == 2 || NG == 4)) begin : g_bad_ng
    $error("blake_state_sequencer: NG must be 1, 2 or 4");
  end

  state_e         state_q, state_d;
  logic [16*W-1:0] v_q, v_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [4:0]     round_q, round_d;
  logic [16*W-1:0] v_merged;
  logic [W-1:0]   vw [16];

  blake_state_merge #(
    .W (W),
    .NG(NG),
    .SW(SW)
  ) u_merge (
    .v_i   (v_q),
    .slot_i(slot_q),
    .a_i   (g_a_i),
    .b_i   (g_b_i),
    .c_i   (g_c_i),
    .d_i   (g_d_i),
    .v_o   (v_merged)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      slot_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      slot_q  <= slot_d;
      round_q <= round_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    slot_d  = slot_q;
    round_d = round_q;
    unique case (state_q)
      ST_IDLE: begin
        if (init_valid) begin
          v_d     = init_v;
          slot_d  = '0;
          round_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (g_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (g_res_valid_i) begin
          v_d     = v_merged;
          state_d = ST_ISSUE;
          if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            if (round_q == LAST_ROUND) begin
              round_d = '0;
              state_d = ST_DONE;
            end else begin
              round_d = round_q + 5'd1;
            end
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end
      end
      ST_DONE: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: decoded from registered state only
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      vw[i] = v_q[(16-i)*W-1 -: W];
    end
    init_ready = (state_q == ST_IDLE);
    g_valid_o  = (state_q == ST_ISSUE);
    done_valid = (state_q == ST_DONE);
    v_final    = (state_q == ST_DONE) ? v_q : '0;
    g_step_o   = 3'(32'(slot_q) * NG);
    g_round_o  = round_q;
    g_a_o      = '0;
    g_b_o      = '0;
    g_c_o      = '0;
    g_d_o      = '0;
    if (state_q == ST_ISSUE) begin
      for (int unsigned k = 0; k < NG; k++) begin
        g_a_o[(NG-k)*W-1 -: W] = vw[a_idx(3'(32'(slot_q) * NG + k))];
        g_b_o[(NG-k)*W-1 -: W] = vw[b_idx(3'(32'(slot_q) * NG + k))];
        g_c_o[(NG-k)*W-1 -: W] = vw[c_idx(3'(32'(slot_q) * NG + k))];
        g_d_o[(NG-k)*W-1 -: W] = vw[d_idx(3'(32'(slot_q) * NG + k))];
      end
    end
  end

`ifdef BLAKE_STATE_PROTO_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (g_res_valid_i && (state_q != ST_WAIT)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
